mulu_seq: RTL and testbench
===========================

// Module: mulu_seq
// PURPOSE
//  Iterative unsigned shift-add multiplier: the inverse arithmetic partner of the divu divider.
//  Uses the same start/busy handshake and operand widths, so q*b + r rebuilds a divu dividend.
//  Lives in the CPU execute path next to divu; also serves as a round-trip checker for it.
//  Computes one partial product per clock; latency is fixed and independent of operand values.
// PARAMETERS
//  WIDTH_A  32  multiplicand width (matches divu dividend/quotient width)
//  WIDTH_B  16  multiplier width (matches divu divisor/remainder width); also the latency in cycles
// PORTS
//  clk     in   1                  rising-edge clock; the only clock
//  resetn  in   1                  asynchronous, active-low reset
//  a       in   WIDTH_A            multiplicand, sampled only on an accepted start
//  b       in   WIDTH_B            multiplier, sampled only on an accepted start
//  start   in   1                  request; level-sampled at posedge
//  z       out  WIDTH_A+WIDTH_B    product; holds the last completed result
//  busy    out  1                  high while a multiply is in progress
//  ready   out  1                  one-cycle pulse; z is valid and newly updated
// BEHAVIOUR
//  Reset (async, resetn=0): z=0, busy=0, ready=0, state=IDLE, count=0. All internal registers are cleared.
//  FSM states:
//   - IDLE -> RUN on the posedge where start=1 and busy=0.
//     - Latch mcand=a; latch mplr=b; acc=0; count=WIDTH_B; busy<=1.
//   - RUN, each cycle:
//     - If mplr[0], add mcand into the upper WIDTH_A+1 bits of acc. Carry is kept.
//     - Shift {acc,mplr} right by 1; count-=1.
//   - RUN -> IDLE when count reaches 0:
//     - z<=final acc (low WIDTH_A+WIDTH_B bits), busy<=0, ready<=1 for exactly one cycle.
//  Latency:
//   - busy is high for exactly WIDTH_B cycles.
//   - ready asserts on the edge where busy falls, WIDTH_B cycles after the accepting edge.
//  Handshake:
//   - start while busy=1 is ignored; the in-flight operation and its latched operands are unaffected.
//   - start held high continuously re-triggers on the first edge with busy=0.
//     That edge is one cycle after the ready pulse, so the back-to-back period is WIDTH_B+1 cycles.
//   - a/b may change freely after the accepting edge.
//  Arithmetic:
//   - The product is exact with no overflow, because the result width is WIDTH_A+WIDTH_B.
//   - The adder is WIDTH_A+1 bits wide so its carry is preserved into the shift.
//  Boundaries:
//   - a=0 or b=0: still takes the full WIDTH_B cycles, and z=0.
//   - All-ones operands: z = (2^WIDTH_A-1)*(2^WIDTH_B-1), with no truncation.
//   - z changes only on completion; ready=0 at all other times.
//   - resetn low mid-RUN: immediately abort to the reset values.
//     After release, no stale ready pulse occurs and the next start begins cleanly.
// STRUCTURE
//  Shared package/header mul_defs:
//   - FSM state encodings IDLE/RUN.
//   - Default width constants, shared with divu.
//   - Count width function clog2(WIDTH_B+1).
//  One sub-module, mulu_step (combinational):
//   - Inputs {acc,mplr} and mcand; output the next {acc,mplr}.
//   - Performs the conditional add and shift.
//  Top level holds only the FSM, counter, operand registers and output registers.
// TESTING
//  1. Hold resetn=0 for 30ns, then release; start=1 with a=16, b=4.
//     Expect busy high for 16 cycles, then z=64, ready pulse 1 cycle, busy=0.
//  2. a=18, b=5 -> z=90; z holds 90 while idle; ready is never high outside completion.
//  3. a=32'hFFFFFFFF, b=16'hFFFF -> z=48'hFFFEFFFF0001. Also a=0, b=16'hFFFF -> z=0 after the full 16 cycles.
//  4. While busy, pulse start with a=7, b=3.
//     The in-flight result is unaffected. Start held high gives back-to-back results with a 17-cycle period.
//  5. Assert resetn=0 at cycle 8 of RUN: busy, ready and z clear at once. A fresh start (3*3) then yields z=9.
//  6. Round-trip with divu: feed q and r from divu(a,b) into mulu_seq(q,b), then add r.
//     Check the sum equals a for 1000 random pairs, b!=0.

Source files
------------

// File: rtl/mul_defs.sv
// Shared definitions for the mulu_seq multiplier and its divu partner:
// FSM encoding, default operand widths and the iteration-counter width helper.
package mul_defs;

    localparam int unsigned DEF_WIDTH_A = 32;
    localparam int unsigned DEF_WIDTH_B = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } mul_state_e;

    // Counter must hold the value WIDTH_B itself, not just WIDTH_B-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mulu_step.sv
// One shift-add iteration: conditionally add mcand into the upper part of {acc,mplr},
// then shift the whole register right by one.
module mulu_step
    import mul_defs::*;
#(
    parameter int unsigned WIDTH_A = DEF_WIDTH_A,
    parameter int unsigned WIDTH_B = DEF_WIDTH_B
) (
    input  logic [WIDTH_A+WIDTH_B:0] i_prod,
    input  logic [WIDTH_A-1:0]       i_mcand,
    output logic [WIDTH_A+WIDTH_B:0] o_prod
);

    logic [WIDTH_A:0] w_addend;
    logic [WIDTH_A:0] w_acc_sum;

    assign w_addend  = i_prod[0] ? {1'b0, i_mcand} : '0;
    // The acc field's top bit is always zero here, so the carry lands in it without loss.
    assign w_acc_sum = i_prod[WIDTH_A+WIDTH_B:WIDTH_B] + w_addend;
    assign o_prod    = {1'b0, w_acc_sum, i_prod[WIDTH_B-1:1]};

endmodule

// File: rtl/mulu_seq.sv
// Iterative unsigned shift-add multiplier with a start/busy/ready handshake.
// One partial product per clock; busy is high for exactly WIDTH_B cycles.
module mulu_seq
    import mul_defs::*;
#(
    parameter int unsigned WIDTH_A = DEF_WIDTH_A,
    parameter int unsigned WIDTH_B = DEF_WIDTH_B
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    input  logic                       start,
    output logic [WIDTH_A+WIDTH_B-1:0] z,
    output logic                       busy,
    output logic                       ready
);

    localparam int unsigned CW = cnt_width(WIDTH_B);
    localparam int unsigned PW = WIDTH_A + WIDTH_B + 1;

    mul_state_e                 r_state, w_state_nxt;
    logic [CW-1:0]              r_count, w_count_nxt;
    logic [WIDTH_A-1:0]         r_mcand, w_mcand_nxt;
    logic [PW-1:0]              r_prod, w_prod_nxt;
    logic [PW-1:0]              w_prod_step;
    logic [WIDTH_A+WIDTH_B-1:0] r_z, w_z_nxt;
    logic                       r_busy, w_busy_nxt;
    logic                       r_ready, w_ready_nxt;

    mulu_step #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B)
    ) u_step (
        .i_prod  (r_prod),
        .i_mcand (r_mcand),
        .o_prod  (w_prod_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mcand_nxt = r_mcand;
        w_prod_nxt  = r_prod;
        w_z_nxt     = r_z;
        w_busy_nxt  = r_busy;
        w_ready_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && !r_busy) begin
                    w_mcand_nxt = a;
                    w_prod_nxt  = {{(WIDTH_A + 1){1'b0}}, b};
                    w_count_nxt = CW'(WIDTH_B);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = StRun;
                end
            end
            StRun: begin
                w_prod_nxt  = w_prod_step;
                w_count_nxt = r_count - CW'(1);
                // Last iteration: publish the product formed by this very step.
                if (r_count == CW'(1)) begin
                    w_z_nxt     = w_prod_step[WIDTH_A+WIDTH_B-1:0];
                    w_busy_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_count <= '0;
            r_mcand <= '0;
            r_prod  <= '0;
            r_z     <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_mcand <= w_mcand_nxt;
            r_prod  <= w_prod_nxt;
            r_z     <= w_z_nxt;
            r_busy  <= w_busy_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign z     = r_z;
    assign busy  = r_busy;
    assign ready = r_ready;

endmodule

// File: tb/tb_mulu_seq.sv
// Scoreboard bench for mulu_seq: stimulus pushes expected products, a negedge monitor
// pops and checks value, latency, busy width and z stability; includes a divu round-trip.
module tb_mulu_seq;

    localparam int unsigned WA = 32;
    localparam int unsigned WB = 16;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [WA-1:0]    a = '0;
    logic [WB-1:0]    b = '0;
    logic             start = 1'b0;
    logic [WA+WB-1:0] z;
    logic             busy;
    logic             ready;

    // Check passes when z + addend == target.
    typedef struct {
        logic [63:0] target;
        logic [63:0] addend;
        longint      acc_cyc;
    } item_t;

    item_t  sb[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    logic [WA+WB-1:0] last_z = '0;
    int     busy_run = 0;

    mulu_seq #(
        .WIDTH_A (WA),
        .WIDTH_B (WB)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .a      (a),
        .b      (b),
        .start  (start),
        .z      (z),
        .busy   (busy),
        .ready  (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Monitor: every ready must match the oldest outstanding request.
    always @(negedge clk) begin
        item_t it;
        if (!resetn) begin
            last_z   = '0;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (ready) begin
                if (sb.size() == 0) begin
                    check("spurious_ready", 64'(ready), 64'(0));
                end else begin
                    it = sb.pop_front();
                    check("product", 64'(z) + it.addend, it.target);
                    check("latency", 64'(cyc - it.acc_cyc), 64'(WB));
                    check("busy_width", 64'(busy_run), 64'(WB));
                    check("busy_low_at_ready", 64'(busy), 64'(0));
                end
                busy_run = 0;
                last_z   = z;
            end else begin
                check("z_stable", 64'(z), 64'(last_z));
            end
        end
    end

    task automatic issue(input logic [WA-1:0] ia, input logic [WB-1:0] ib,
                         input logic [63:0] tgt, input logic [63:0] add,
                         input bit keep, output longint acc);
        int n = 0;
        acc = -1;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            fail("issue_wait_idle");
            return;
        end
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        sb.push_back('{tgt, add, cyc});
        if (!keep) start = 1'b0;
    endtask

    task automatic mul(input logic [WA-1:0] ia, input logic [WB-1:0] ib, input bit keep,
                       output longint acc);
        issue(ia, ib, 64'(ia) * 64'(ib), 64'(0), keep, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) fail("drain");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc, prev;
        logic [WA-1:0] ra, rq, rr;
        logic [WB-1:0] rb;

        #25;
        check("reset_z", 64'(z), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_ready", 64'(ready), 64'(0));
        #5 resetn = 1'b1;

        mul(32'd16, 16'd4, 1'b0, acc);
        drain();
        mul(32'd18, 16'd5, 1'b0, acc);
        drain();
        repeat (10) @(negedge clk);
        check("z_holds_90", 64'(z), 64'd90);

        mul(32'hFFFF_FFFF, 16'hFFFF, 1'b0, acc);
        drain();
        check("all_ones", 64'(z), 64'h0000_FFFE_FFFF_0001);
        mul(32'd0, 16'hFFFF, 1'b0, acc);
        drain();
        mul(32'hDEAD_BEEF, 16'd0, 1'b0, acc);
        drain();

        // start while busy must be ignored
        mul(32'd1000, 16'd777, 1'b0, acc);
        repeat (5) @(negedge clk);
        a = 32'd7;
        b = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = 16'($urandom);
        drain();
        repeat (20) @(negedge clk);

        // start held high: back-to-back period is WB+1
        mul($urandom, 16'($urandom), 1'b1, prev);
        for (int k = 0; k < 3; k++) begin
            mul($urandom, 16'($urandom), 1'b1, acc);
            check("b2b_period", 64'(acc - prev), 64'(WB + 1));
            prev = acc;
        end
        start = 1'b0;
        drain();

        // async reset mid-run
        mul(32'd12345, 16'd678, 1'b0, acc);
        repeat (8) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_ready", 64'(ready), 64'(0));
        check("abort_z", 64'(z), 64'(0));
        sb.delete();
        #13 resetn = 1'b1;
        repeat (25) @(negedge clk);
        mul(32'd3, 16'd3, 1'b0, acc);
        drain();
        check("after_reset_9", 64'(z), 64'd9);

        // divu round trip: q*b + r must rebuild a
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = 16'($urandom_range(65535, 1));
            rq = ra / 32'(rb);
            rr = ra % 32'(rb);
            issue(rq, rb, 64'(ra), 64'(rr), 1'b1, acc);
        end
        start = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
